// File: rtl/png_feed_ctrl_if.sv
// ---------------------------------------------------------------------------
// png_feed_ctrl_if
// Handshake bundle between the NIC packet side, the feed sequencer and the
// hard PNG decoder input port.
//
//   pkt_valid/pkt_ready : packet word handshake (NIC -> sequencer)
//   pkt_data            : 8*PKT_BYTES packet bytes, byte 0 in the MSBs
//   pkt_len             : valid byte count of the word
//   pkt_sof/pkt_eof     : first / last word of an image
//   dec_istart          : one-cycle decoder start pulse
//   dec_ivalid/iready   : byte handshake (sequencer -> decoder)
//   dec_ibyte           : byte to the decoder
//
// modport master : environment view (drives packets, drives dec_iready)
// modport slave  : sequencer view (png_feed_ctrl)
// ---------------------------------------------------------------------------
interface png_feed_ctrl_if #(
  parameter int PKT_BYTES = 69,
  parameter int LEN_W     = 7
);
  logic                   pkt_valid;
  logic                   pkt_ready;
  logic [8*PKT_BYTES-1:0] pkt_data;
  logic [LEN_W-1:0]       pkt_len;
  logic                   pkt_sof;
  logic                   pkt_eof;
  logic                   dec_istart;
  logic                   dec_ivalid;
  logic [7:0]             dec_ibyte;
  logic                   dec_iready;

  modport master (
    output pkt_valid, pkt_data, pkt_len, pkt_sof, pkt_eof, dec_iready,
    input  pkt_ready, dec_istart, dec_ivalid, dec_ibyte
  );

  modport slave (
    input  pkt_valid, pkt_data, pkt_len, pkt_sof, pkt_eof, dec_iready,
    output pkt_ready, dec_istart, dec_ivalid, dec_ibyte
  );
endinterface

// File: rtl/png_feed_ctrl.sv
// ---------------------------------------------------------------------------
// png_feed_ctrl
// Sequencer between the NIC packet interface and the hard PNG decoder.
// Accepts wide packet words, frames them into images with a one-cycle
// decoder start pulse and serialises bytes MSB-first to the decoder under a
// valid/ready handshake. Detects stalls (timeout), framing faults and end of
// image, and reports status.
//
// Ports:
//   clk        : system clock
//   rstn       : asynchronous active-low reset
//   bus        : png_feed_ctrl_if.slave (packet and decoder handshakes)
//   busy       : image in progress (state other than IDLE)
//   done       : one-cycle pulse after the last byte of the eof word
//   err        : one-cycle error pulse
//   err_code   : last error (001 timeout, 010 sof mid-image,
//                011 orphan packet, 100 bad signature), held until next err
//   byte_count : bytes transferred in the current image
//
// Optional feature macro: PNG_SIG_CHECK_EN
//   When defined, the first 8 bytes of each image are checked against the
//   PNG signature 89 50 4E 47 0D 0A 1A 0A; a mismatch aborts the image.
// ---------------------------------------------------------------------------
module png_feed_ctrl #(
  parameter int PKT_BYTES   = 69,
  parameter int LEN_W       = 7,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rstn,
  png_feed_ctrl_if.slave    bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        err_code,
  output logic [31:0]       byte_count
);

  localparam int WORD_W = 8 * PKT_BYTES;
  localparam int TMO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  localparam logic [2:0] ERR_TIMEOUT = 3'b001;
  localparam logic [2:0] ERR_SOF_MID = 3'b010;
  localparam logic [2:0] ERR_ORPHAN  = 3'b011;
  localparam logic [2:0] ERR_SIG     = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_FEED,
    S_WAIT_PKT
  } state_t;

  state_t             state_q;
  logic [WORD_W-1:0]  word_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   idx_q;
  logic               eof_q;
  logic [TMO_W-1:0]   tmo_q;
  logic               done_q;
  logic               err_q;
  logic [2:0]         code_q;
  logic [31:0]        cnt_q;

  logic               accept;
  logic               xfer;
  logic [LEN_W-1:0]   len_d;
  logic               last_byte;
  logic               tmo_hit;
  logic               sig_bad;
  logic [WORD_W-1:0]  word_sh;

  // Handshake outputs are pure decodes of the state register.
  assign bus.pkt_ready  = (state_q == S_IDLE) || (state_q == S_WAIT_PKT);
  assign bus.dec_istart = (state_q == S_START);
  assign bus.dec_ivalid = (state_q == S_FEED);

  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = code_q;
  assign byte_count = cnt_q;

  assign accept = bus.pkt_valid && bus.pkt_ready;
  assign xfer   = bus.dec_ivalid && bus.dec_iready;

  // Oversized lengths are clamped to the physical word size.
  assign len_d = (bus.pkt_len > LEN_W'(PKT_BYTES)) ? LEN_W'(PKT_BYTES) : bus.pkt_len;

  assign last_byte = (idx_q == (len_q - LEN_W'(1)));

  // Fires on the stall cycle that would bring the counter to TIMEOUT_CYC.
  assign tmo_hit = (TIMEOUT_CYC != 0) && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  // Byte 0 lives in the MSBs: shift the selected byte up to the top.
  assign word_sh       = word_q << {idx_q, 3'b000};
  assign bus.dec_ibyte = word_sh[WORD_W-1 -: 8];

`ifdef PNG_SIG_CHECK_EN
  logic [3:0] sig_cnt_q;

  function automatic logic [7:0] sig_byte(input logic [2:0] i);
    logic [7:0] b;
    case (i)
      3'd0:    b = 8'h89;
      3'd1:    b = 8'h50;
      3'd2:    b = 8'h4E;
      3'd3:    b = 8'h47;
      3'd4:    b = 8'h0D;
      3'd5:    b = 8'h0A;
      3'd6:    b = 8'h1A;
      default: b = 8'h0A;
    endcase
    return b;
  endfunction

  // sig_cnt_q saturates at 8 so only the first 8 bytes of an image are checked.
  assign sig_bad = xfer && !sig_cnt_q[3] && (bus.dec_ibyte != sig_byte(sig_cnt_q[2:0]));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sig_cnt_q <= '0;
    end else if (state_q == S_START) begin
      sig_cnt_q <= '0;
    end else if (xfer && !sig_cnt_q[3]) begin
      sig_cnt_q <= sig_cnt_q + 4'd1;
    end
  end
`else
  assign sig_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      eof_q   <= 1'b0;
      tmo_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tmo_q <= '0;
          if (accept) begin
            if (bus.pkt_sof) begin
              word_q  <= bus.pkt_data;
              len_q   <= len_d;
              eof_q   <= bus.pkt_eof;
              idx_q   <= '0;
              cnt_q   <= '0;
              state_q <= S_START;
            end else begin
              err_q  <= 1'b1;
              code_q <= ERR_ORPHAN;
            end
          end
        end

        S_START: begin
          if (len_q == '0) begin
            if (eof_q) begin
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              state_q <= S_WAIT_PKT;
            end
          end else begin
            state_q <= S_FEED;
          end
        end

        S_FEED: begin
          if (xfer) begin
            cnt_q <= cnt_q + 32'd1;
            tmo_q <= '0;
            // A signature error on the final byte beats completion.
            if (sig_bad) begin
              err_q   <= 1'b1;
              code_q  <= ERR_SIG;
              state_q <= S_IDLE;
            end else if (last_byte) begin
              if (eof_q) begin
                done_q  <= 1'b1;
                state_q <= S_IDLE;
              end else begin
                state_q <= S_WAIT_PKT;
              end
            end else begin
              idx_q <= idx_q + LEN_W'(1);
            end
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            code_q  <= ERR_TIMEOUT;
            tmo_q   <= '0;
            state_q <= S_IDLE;
          end else if (TIMEOUT_CYC != 0) begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end

        S_WAIT_PKT: begin
          if (accept) begin
            word_q <= bus.pkt_data;
            len_q  <= len_d;
            eof_q  <= bus.pkt_eof;
            idx_q  <= '0;
            tmo_q  <= '0;
            if (bus.pkt_sof) begin
              // Abandon the current image and restart with the new one.
              err_q   <= 1'b1;
              code_q  <= ERR_SOF_MID;
              cnt_q   <= '0;
              state_q <= S_START;
            end else if (len_d == '0) begin
              if (bus.pkt_eof) begin
                done_q  <= 1'b1;
                state_q <= S_IDLE;
              end
            end else begin
              state_q <= S_FEED;
            end
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            code_q  <= ERR_TIMEOUT;
            tmo_q   <= '0;
            state_q <= S_IDLE;
          end else if (TIMEOUT_CYC != 0) begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_png_feed_ctrl.sv
// ---------------------------------------------------------------------------
// tb_png_feed_ctrl
// Directed bench for png_feed_ctrl. Images are built from a fixed byte
// pattern that starts with the PNG signature and ends with AE 42 60 82.
// ---------------------------------------------------------------------------
module tb_png_feed_ctrl;

  localparam int PB  = 69;
  localparam int LW  = 7;
  localparam int TMO = 16;
  localparam int WW  = 8 * PB;

  logic        clk;
  logic        rstn;
  logic        busy;
  logic        done;
  logic        err;
  logic [2:0]  err_code;
  logic [31:0] byte_count;

  png_feed_ctrl_if #(.PKT_BYTES(PB), .LEN_W(LW)) bus ();

  png_feed_ctrl #(.PKT_BYTES(PB), .LEN_W(LW), .TIMEOUT_CYC(TMO)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus.slave),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code),
    .byte_count (byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference image byte i (0..68).
  function automatic logic [7:0] img_byte(input int i);
    logic [7:0] sig [8];
    logic [7:0] tail [4];
    sig  = '{8'h89, 8'h50, 8'h4E, 8'h47, 8'h0D, 8'h0A, 8'h1A, 8'h0A};
    tail = '{8'hAE, 8'h42, 8'h60, 8'h82};
    if (i < 8)        return sig[i];
    else if (i >= 65) return tail[i-65];
    else              return 8'((i * 37 + 11) & 255);
  endfunction

  // Pack image bytes [first .. first+len-1] MSB-first; bad_idx gets 0x48.
  function automatic logic [WW-1:0] mk_word(input int first, input int len, input int bad_idx);
    logic [WW-1:0] w;
    w = '0;
    for (int i = 0; i < len; i++)
      w[WW-1-8*i -: 8] = (first + i == bad_idx) ? 8'h48 : img_byte(first + i);
    return w;
  endfunction

  // Word schedule
  logic [WW-1:0] w_data [4];
  int            w_len  [4];
  bit            w_sof  [4];
  bit            w_eof  [4];
  int            w_at   [4];
  int            nw;
  int            rdy_mode;

  // Observations of the last run
  int         n_acc, n_istart, n_done, n_err, n_stall, n_unstable, n_both;
  int         n_rdy_busy, n_rdy_feed;
  int         cyc_istart, cyc_first_val, cyc_last_xfer, cyc_done, cyc_err;
  logic [31:0] bc_at_err;
  logic [7:0] got [$];
  int         mism;

  task automatic set_word(input int i, input logic [WW-1:0] d, input int len,
                          input bit sof, input bit eof, input int at);
    w_data[i] = d; w_len[i] = len; w_sof[i] = sof; w_eof[i] = eof; w_at[i] = at;
  endtask

  task automatic run(input int ncyc);
    bit         acc;
    bit         prev_stall;
    logic [7:0] prev_byte;
    n_acc = 0; n_istart = 0; n_done = 0; n_err = 0; n_stall = 0; n_unstable = 0;
    n_both = 0; n_rdy_busy = 0; n_rdy_feed = 0;
    cyc_istart = -1; cyc_first_val = -1; cyc_last_xfer = -1; cyc_done = -1; cyc_err = -1;
    bc_at_err = '0; got.delete(); prev_stall = 1'b0; prev_byte = '0;
    for (int c = 0; c < ncyc; c++) begin
      if (!bus.pkt_valid && n_acc < nw && c >= w_at[n_acc]) begin
        bus.pkt_valid = 1'b1;
        bus.pkt_data  = w_data[n_acc];
        bus.pkt_len   = LW'(w_len[n_acc]);
        bus.pkt_sof   = w_sof[n_acc];
        bus.pkt_eof   = w_eof[n_acc];
      end
      @(negedge clk);
      acc = bus.pkt_valid && bus.pkt_ready;
      if (acc) n_acc++;
      if (bus.dec_istart) begin n_istart++; cyc_istart = c; end
      if (bus.dec_ivalid) begin
        if (prev_stall && bus.dec_ibyte !== prev_byte) n_unstable++;
        if (cyc_first_val < 0) cyc_first_val = c;
        if (bus.dec_iready) begin got.push_back(bus.dec_ibyte); cyc_last_xfer = c; end
        else n_stall++;
        prev_stall = !bus.dec_iready;
        prev_byte  = bus.dec_ibyte;
      end else begin
        prev_stall = 1'b0;
      end
      if (done) begin n_done++; cyc_done = c; end
      if (err) begin n_err++; cyc_err = c; bc_at_err = byte_count; end
      if (done && err) n_both++;
      if (busy && bus.pkt_ready) n_rdy_busy++;
      if (bus.dec_ivalid && bus.pkt_ready) n_rdy_feed++;
      @(posedge clk);
      #1;
      if (acc) bus.pkt_valid = 1'b0;
      case (rdy_mode)
        1:       bus.dec_iready = ((c + 1) % 3 == 0);
        2:       bus.dec_iready = (got.size() == 0);
        default: bus.dec_iready = 1'b1;
      endcase
    end
  endtask

  // Compare got[from .. from+len-1] with image bytes [0 .. len-1].
  task automatic cmp_bytes(input int from, input int len);
    mism = 0;
    for (int i = 0; i < len; i++)
      if (from + i >= got.size() || got[from+i] !== img_byte(i)) mism++;
  endtask

  initial begin
    rstn           = 1'b0;
    bus.pkt_valid  = 1'b0;
    bus.pkt_data   = '0;
    bus.pkt_len    = '0;
    bus.pkt_sof    = 1'b0;
    bus.pkt_eof    = 1'b0;
    bus.dec_iready = 1'b1;
    rdy_mode       = 0;
    nw             = 0;

    // Reset state (before any clock edge: reset is asynchronous)
    #3;
    chk("rst_pkt_ready", bus.pkt_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done_err", {done, err, bus.dec_istart, bus.dec_ivalid}, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_byte_count", byte_count, 0);
    chk("rst_dec_ibyte", bus.dec_ibyte, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // Single full word, decoder always ready
    nw = 1; rdy_mode = 0;
    set_word(0, mk_word(0, 69, -1), 69, 1, 1, 0);
    run(80);
    cmp_bytes(0, 69);
    chk("t1_istart_n", n_istart, 1);
    chk("t1_istart_cyc", cyc_istart, 1);
    chk("t1_first_valid_cyc", cyc_first_val, 2);
    chk("t1_nbytes", got.size(), 69);
    chk("t1_byte_mism", mism, 0);
    chk("t1_first_byte", got[0], 8'h89);
    chk("t1_last_byte", got[68], 8'h82);
    chk("t1_last_xfer_cyc", cyc_last_xfer, 70);
    chk("t1_done_cyc", cyc_done, 71);
    chk("t1_done_n", n_done, 1);
    chk("t1_err_n", n_err, 0);
    chk("t1_byte_count", byte_count, 69);
    chk("t1_busy_end", busy, 0);

    // Oversized pkt_len is clamped to 69
    set_word(0, mk_word(0, 69, -1), 100, 1, 1, 0);
    run(80);
    cmp_bytes(0, 69);
    chk("clamp_nbytes", got.size(), 69);
    chk("clamp_byte_mism", mism, 0);
    chk("clamp_byte_count", byte_count, 69);
    chk("clamp_done_n", n_done, 1);

    // Decoder ready toggling 1,0,0,1,0,0...
    rdy_mode = 1;
    set_word(0, mk_word(0, 69, -1), 69, 1, 1, 0);
    run(230);
    cmp_bytes(0, 69);
    chk("t2_nbytes", got.size(), 69);
    chk("t2_byte_mism", mism, 0);
    chk("t2_unstable", n_unstable, 0);
    chk("t2_stalls_seen", n_stall > 0, 1);
    chk("t2_err_n", n_err, 0);
    chk("t2_done_n", n_done, 1);
    chk("t2_byte_count", byte_count, 69);
    rdy_mode = 0;

    // Split image 40 + 29, second word offered 5 cycles late
    nw = 2;
    set_word(0, mk_word(0, 40, -1), 40, 1, 0, 0);
    set_word(1, mk_word(40, 29, -1), 29, 0, 1, 47);
    run(85);
    cmp_bytes(0, 69);
    chk("t3_accepted", n_acc, 2);
    chk("t3_nbytes", got.size(), 69);
    chk("t3_byte_mism", mism, 0);
    chk("t3_ready_in_wait", n_rdy_busy, 6);
    chk("t3_ready_in_feed", n_rdy_feed, 0);
    chk("t3_istart_n", n_istart, 1);
    chk("t3_done_n", n_done, 1);
    chk("t3_done_cyc", cyc_done, 77);
    chk("t3_byte_count", byte_count, 69);

    // len=0 eof word in WAIT_PKT completes the image
    set_word(0, mk_word(0, 40, -1), 40, 1, 0, 0);
    set_word(1, '0, 0, 0, 1, 45);
    run(55);
    chk("len0_accepted", n_acc, 2);
    chk("len0_done_cyc", cyc_done, 46);
    chk("len0_err_n", n_err, 0);
    chk("len0_byte_count", byte_count, 40);

    // Timeout: decoder stalls after first byte
    nw = 1; rdy_mode = 2;
    set_word(0, mk_word(0, 69, -1), 69, 1, 1, 0);
    run(30);
    chk("t4_err_n", n_err, 1);
    chk("t4_err_cyc", cyc_err, 19);
    chk("t4_err_code", err_code, 3'b001);
    chk("t4_busy", busy, 0);
    chk("t4_byte_count", byte_count, 1);
    chk("t4_done_n", n_done, 0);
    rdy_mode = 0;

    // Second sof while waiting for a continuation word
    nw = 2;
    set_word(0, mk_word(0, 40, -1), 40, 1, 0, 0);
    set_word(1, mk_word(0, 69, -1), 69, 1, 1, 47);
    run(125);
    cmp_bytes(40, 69);
    chk("t5_err_n", n_err, 1);
    chk("t5_err_code", err_code, 3'b010);
    chk("t5_istart_n", n_istart, 2);
    chk("t5_istart_cyc", cyc_istart, cyc_err);
    chk("t5_bc_at_err", bc_at_err, 0);
    chk("t5_nbytes", got.size(), 109);
    chk("t5_byte_mism", mism, 0);
    chk("t5_done_n", n_done, 1);
    chk("t5_byte_count", byte_count, 69);
    chk("t5_done_err_same", n_both, 0);

    // Orphan (non-sof) word in IDLE
    nw = 1;
    set_word(0, mk_word(0, 4, -1), 4, 0, 1, 0);
    run(10);
    chk("orph_accepted", n_acc, 1);
    chk("orph_err_n", n_err, 1);
    chk("orph_err_cyc", cyc_err, 1);
    chk("orph_err_code", err_code, 3'b011);
    chk("orph_istart_n", n_istart, 0);
    chk("orph_busy_ready", n_rdy_busy, 0);
    chk("orph_byte_count_held", byte_count, 69);

`ifdef PNG_SIG_CHECK_EN
    // Bad signature byte 3 = 0x48
    set_word(0, mk_word(0, 69, 3), 69, 1, 1, 0);
    run(20);
    chk("sig_err_cyc", cyc_err, 6);
    chk("sig_err_code", err_code, 3'b100);
    chk("sig_nbytes", got.size(), 4);
    chk("sig_byte_count", byte_count, 4);
    chk("sig_done_n", n_done, 0);
    chk("sig_busy", busy, 0);
`endif

    // Asynchronous reset in the middle of an image
    set_word(0, mk_word(0, 69, -1), 69, 1, 1, 0);
    run(10);
    chk("mid_busy_before", busy, 1);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_pkt_ready", bus.pkt_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ivalid", bus.dec_ivalid, 0);
    chk("mid_rst_byte_count", byte_count, 0);
    chk("mid_rst_err_code", err_code, 0);
    chk("mid_rst_dec_ibyte", bus.dec_ibyte, 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/png_feed_ctrl.md
Name: png_feed_ctrl

Overview:
Sequencer between the NIC packet interface and the hard PNG decoder. Accepts wide packet words, frames them into images with a one-cycle decoder start pulse, and serialises bytes MSB-first to the decoder under a valid/ready handshake. Detects stalls, framing faults and end of image, and reports status.

Parameters:
PKT_BYTES, 69, maximum bytes per packet word (pkt_data width = 8*PKT_BYTES)
LEN_W, 7, width of pkt_len; must satisfy 2**LEN_W > PKT_BYTES
TIMEOUT_CYC, 4096, stall cycles before abort; 0 disables the timeout

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
pkt_valid  in  1  packet word offered
pkt_ready  out  1  packet word accepted when pkt_valid && pkt_ready at posedge
pkt_data  in  8*PKT_BYTES  packet bytes; byte 0 = pkt_data[8*PKT_BYTES-1 -: 8]
pkt_len  in  LEN_W  valid byte count; values above PKT_BYTES are clamped to PKT_BYTES
pkt_sof  in  1  first packet of an image
pkt_eof  in  1  last packet of an image
dec_istart  out  1  one-cycle decoder start pulse
dec_ivalid  out  1  dec_ibyte valid
dec_ibyte  out  8  byte to decoder
dec_iready  in  1  decoder accepts byte
busy  out  1  image in progress (state other than IDLE)
done  out  1  one-cycle pulse after the last byte of the eof packet transfers
err  out  1  one-cycle error pulse
err_code  out  3  last error: 001 timeout, 010 sof mid-image, 011 orphan packet, 100 bad signature; held until the next err
byte_count  out  32  bytes transferred in the current image; cleared on dec_istart; held after done or abort

Behaviour:
- Reset (asynchronous, immediate, including mid-image): state IDLE; all outputs 0 except pkt_ready=1; internal byte register, index and timeout counter cleared.
- States: IDLE, START, FEED, WAIT_PKT.
- pkt_ready = 1 in IDLE and WAIT_PKT, 0 in START and FEED. Accepting a word registers pkt_data and clamped pkt_len, and clears the byte index.
- IDLE:
  - Accept with sof=1 -> START.
  - Accept with sof=0 -> word dropped; err pulse, err_code=011; stay IDLE.
- START: dec_istart=1 for exactly one cycle; byte_count<=0 -> FEED.
  - Latency: sof word accepted at edge N; dec_istart high in cycle N+1; first dec_ivalid in cycle N+2.
- FEED:
  - dec_ivalid=1; dec_ibyte = byte[index] (combinational from the registered word).
  - A transfer (dec_ivalid && dec_iready at posedge) increments index and byte_count.
  - dec_ibyte is stable while stalled.
  - On the transfer of byte index len-1:
    - eof word -> done pulse next cycle, -> IDLE.
    - otherwise -> WAIT_PKT.
  - A len=0 word skips FEED: eof -> done, IDLE; else WAIT_PKT.
- WAIT_PKT:
  - Accept with sof=0 -> FEED; dec_ivalid high the next cycle.
  - Accept with sof=1 -> err pulse, err_code=010; current image abandoned; -> START (new image).
- Timeout:
  - Counter increments each cycle in FEED with !dec_iready, and each cycle in WAIT_PKT with no accept; it clears on any transfer or accept.
  - Counter reaching TIMEOUT_CYC -> err pulse, err_code=001, -> IDLE; no done.
- byte_count wraps at 2^32 with no flag.
- done and err never assert in the same cycle. If an error and completion coincide, the error wins.
- Back-to-back images: a new sof word may be accepted in IDLE the cycle after done.

Optional Feature:
PNG_SIG_CHECK_EN
- Defined: the first 8 bytes transferred after dec_istart are compared to 89 50 4E 47 0D 0A 1A 0A.
  - A mismatch is detected on the transferring edge -> err pulse, err_code=100, -> IDLE.
  - The mismatching byte is still transferred and counted in byte_count.
- Undefined: no check; err_code 100 is never produced.

Test Plan:
- One word, len=69, sof=eof=1, data 89504E47...AE426082, dec_iready=1 -> dec_istart one cycle; 69 transfers on consecutive cycles, first 0x89, last 0x82; done one cycle later; byte_count=69.
- Same image with dec_iready toggling 1,0,0,1... -> dec_ibyte stable across stalls; byte sequence identical; byte_count=69; no err.
- Image split into words len=40 (sof) and len=29 (eof), second word offered 5 cycles late -> pkt_ready high only in WAIT_PKT; 69 bytes in order; single done.
- TIMEOUT_CYC=16, dec_iready held 0 after the first byte -> err at stall cycle 16, err_code=001, busy=0, byte_count=1, no done.
- Second sof word in WAIT_PKT -> err_code=010, new dec_istart, byte_count restarts at 0. A non-sof word in IDLE -> err_code=011, no dec_istart.
- With PNG_SIG_CHECK_EN, byte 3 = 0x48 -> err_code=100 after the 4th transfer, byte_count=4, IDLE.
